// File: rtl/cmp_pipe_configurable_pkg.sv
// Shared types for the pipelined magnitude comparator: relational op encoding
// and the final op decode applied to the resolved {lt, eq} state.
package cmp_pipe_configurable_pkg;

  typedef enum logic [2:0] {
    OP_LT    = 3'd0,
    OP_LE    = 3'd1,
    OP_GT    = 3'd2,
    OP_GE    = 3'd3,
    OP_EQ    = 3'd4,
    OP_NE    = 3'd5,
    OP_RSVD6 = 3'd6,
    OP_RSVD7 = 3'd7
  } cmp_op_e;

  function automatic logic op_result(cmp_op_e op, logic lt, logic eq);
    case (op)
      OP_LT:   return lt;
      OP_LE:   return lt | eq;
      OP_GT:   return !lt && !eq;
      OP_GE:   return !lt;
      OP_EQ:   return eq;
      OP_NE:   return !eq;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_pipe_configurable_if.sv
// Operand-issue and result-consumer handshake bundle for the comparator.
// slave is the comparator's view, master is the issuing/consuming side.
interface cmp_pipe_configurable_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic             out_lt;
  logic             out_eq;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_lt, out_eq
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_op, out_ready,
    output in_ready, out_valid, out_y, out_lt, out_eq
  );
endinterface

// File: rtl/cmp_pipe_configurable_chunk_stage.sv
// One CHUNK-wide unsigned compare merged into the running {lt, eq} state.
// Once a higher chunk has differed, the earlier verdict is carried unchanged.
module cmp_pipe_configurable_chunk_stage #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_lt,
  input  logic             i_eq,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_lt = i_eq ? (i_a < i_b) : i_lt;
  assign o_eq = i_eq & (i_a == i_b);

endmodule

// File: rtl/cmp_pipe_configurable.sv
// Pipelined WIDTH-bit comparator resolving one CHUNK per stage, MSB chunk first,
// with bubble-collapsing valid/ready flow control and in-order results.
module cmp_pipe_configurable
  import cmp_pipe_configurable_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cmp_pipe_configurable_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("cmp_pipe_configurable: WIDTH must be a positive multiple of CHUNK");
  end

  logic [STAGES-1:0] w_vld;
  logic [STAGES-1:0] w_load;

  // A stage may load when empty or when its content moves on this cycle.
  always_comb begin : p_load
    logic w_adv;
    w_adv  = w_vld[STAGES-1] & bus.out_ready;
    w_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_load[k] = !w_vld[k] | w_adv;
      w_adv     = w_load[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = WIDTH - (k + 1) * CHUNK;

    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_lt_in;
    logic             w_eq_in;
    logic             w_vld_in;
    cmp_op_e          w_op_in;
    logic             w_lt;
    logic             w_eq;

    logic             r_vld;
    logic             r_lt;
    logic             r_eq;
    cmp_op_e          r_op;

    if (k == 0) begin : g_head
      assign w_ca     = bus.in_a[WIDTH-1 -: CHUNK] ^ (bus.in_signed ? MSB_MASK : '0);
      assign w_cb     = bus.in_b[WIDTH-1 -: CHUNK] ^ (bus.in_signed ? MSB_MASK : '0);
      assign w_lt_in  = 1'b0;
      assign w_eq_in  = 1'b1;
      assign w_vld_in = bus.in_valid;
      assign w_op_in  = cmp_op_e'(bus.in_op);
    end else begin : g_body
      assign w_ca     = g_st[k-1].g_rem.r_a[REM+CHUNK-1 -: CHUNK];
      assign w_cb     = g_st[k-1].g_rem.r_b[REM+CHUNK-1 -: CHUNK];
      assign w_lt_in  = g_st[k-1].r_lt;
      assign w_eq_in  = g_st[k-1].r_eq;
      assign w_vld_in = g_st[k-1].r_vld;
      assign w_op_in  = g_st[k-1].r_op;
    end

    cmp_pipe_configurable_chunk_stage #(
      .CHUNK (CHUNK)
    ) u_cmp (
      .i_a  (w_ca),
      .i_b  (w_cb),
      .i_lt (w_lt_in),
      .i_eq (w_eq_in),
      .o_lt (w_lt),
      .o_eq (w_eq)
    );

    // Stage k register boundary: only the valid bit sees reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
      end else if (w_load[k]) begin
        r_vld <= w_vld_in;
      end
    end

    always_ff @(posedge clk) begin
      if (w_load[k] && w_vld_in) begin
        r_op <= w_op_in;
        r_lt <= w_lt;
        r_eq <= w_eq;
      end
    end

    // Only the still-unresolved low bits travel further down the pipe.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;
      if (k == 0) begin : g_src_in
        always_ff @(posedge clk) begin
          if (w_load[k] && w_vld_in) begin
            r_a <= bus.in_a[REM-1:0];
            r_b <= bus.in_b[REM-1:0];
          end
        end
      end else begin : g_src_prev
        always_ff @(posedge clk) begin
          if (w_load[k] && w_vld_in) begin
            r_a <= g_st[k-1].g_rem.r_a[REM-1:0];
            r_b <= g_st[k-1].g_rem.r_b[REM-1:0];
          end
        end
      end
    end

    assign w_vld[k] = r_vld;
  end

  // Data registers are not reset, so results are qualified by the last valid.
  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = w_vld[STAGES-1];
  assign bus.out_lt    = w_vld[STAGES-1] & g_st[STAGES-1].r_lt;
  assign bus.out_eq    = w_vld[STAGES-1] & g_st[STAGES-1].r_eq;
  assign bus.out_y     = w_vld[STAGES-1] &
                         op_result(g_st[STAGES-1].r_op, g_st[STAGES-1].r_lt, g_st[STAGES-1].r_eq);

endmodule

// File: tb/tb_cmp_pipe_configurable.sv
// Bench for the comparator: a 4-stage 32/8 instance and a 1-stage 16/16 instance,
// directed corner beats plus randomized traffic scored against an arithmetic model.
module tb_cmp_pipe_configurable;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_pipe_configurable_if #(.WIDTH(32)) if0 ();
  cmp_pipe_configurable_if #(.WIDTH(16)) if1 ();

  cmp_pipe_configurable #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  cmp_pipe_configurable #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int          sel;
  logic        drv_valid;
  logic        drv_ready;
  logic        drv_signed;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic [2:0]  drv_op;
  bit          use_exp;
  logic [2:0]  drv_exp;

  assign if0.in_valid  = drv_valid && (sel == 0);
  assign if0.in_a      = drv_a;
  assign if0.in_b      = drv_b;
  assign if0.in_signed = drv_signed;
  assign if0.in_op     = drv_op;
  assign if0.out_ready = (sel == 0) ? drv_ready : 1'b1;
  assign if1.in_valid  = drv_valid && (sel == 1);
  assign if1.in_a      = drv_a[15:0];
  assign if1.in_b      = drv_b[15:0];
  assign if1.in_signed = drv_signed;
  assign if1.in_op     = drv_op;
  assign if1.out_ready = (sel == 1) ? drv_ready : 1'b1;

  typedef struct {
    logic [2:0] res;
    int         t_in;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  bit   lat_on = 0;
  logic last_ir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {y, lt, eq} from the integer values of the operands.
  function automatic logic [2:0] ref_res(logic [31:0] a, logic [31:0] b, logic sg, logic [2:0] op);
    int     w;
    longint m, va, vb;
    logic   lt, eq, y;
    w  = (sel == 0) ? 32 : 16;
    m  = longint'(1) << w;
    va = longint'(a) % m;
    vb = longint'(b) % m;
    if (sg) begin
      if (va >= m / 2) va -= m;
      if (vb >= m / 2) vb -= m;
    end
    lt = (va < vb);
    eq = (va == vb);
    case (op)
      3'd0:    y = lt;
      3'd1:    y = lt || eq;
      3'd2:    y = !lt && !eq;
      3'd3:    y = !lt;
      3'd4:    y = eq;
      3'd5:    y = !eq;
      default: y = 1'b0;
    endcase
    return {y, lt, eq};
  endfunction

  function automatic int stg();
    return (sel == 0) ? 4 : 1;
  endfunction

  // One clock: sample mid-cycle, score outputs, record accepted input, advance.
  task automatic step();
    logic       ov;
    logic [2:0] res;
    exp_t       e;
    #4;
    if (sel == 0) begin
      ov = if0.out_valid; last_ir = if0.in_ready; res = {if0.out_y, if0.out_lt, if0.out_eq};
    end else begin
      ov = if1.out_valid; last_ir = if1.in_ready; res = {if1.out_y, if1.out_lt, if1.out_eq};
    end
    if (ov) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'b0, ov}, {31'b0, q.size() != 0});
      end else begin
        e = q[0];
        chk("result", {29'b0, res}, {29'b0, e.res});
        if (lat_on) chk("latency", cyc - e.t_in, stg());
        if (drv_ready) void'(q.pop_front());
      end
    end
    if (drv_valid && last_ir) begin
      e.res  = use_exp ? drv_exp : ref_res(drv_a, drv_b, drv_signed, drv_op);
      e.t_in = cyc;
      q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic sg,
                      input logic [2:0] op, input bit ue, input logic [2:0] ex, output int tries);
    int acc0;
    acc0 = n_acc;
    tries = 0;
    drv_valid = 1'b1; drv_a = a; drv_b = b; drv_signed = sg; drv_op = op;
    use_exp = ue; drv_exp = ex;
    while (n_acc == acc0 && tries < 20) begin
      step();
      tries++;
    end
    chk("beat_accept", n_acc - acc0, 1);
    drv_valid = 1'b0;
    use_exp = 1'b0;
  endtask

  task automatic drain();
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic rand_operands();
    drv_a = $urandom;
    case ($urandom % 4)
      0:       drv_b = drv_a;
      1:       drv_b = {drv_a[31:8], 8'($urandom)};
      2:       drv_b = drv_a ^ (32'h1 << ($urandom % 32));
      default: drv_b = $urandom;
    endcase
    drv_signed = 1'($urandom % 2);
    drv_op     = 3'($urandom % 8);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acc0;
    sel = 0; drv_valid = 0; drv_ready = 1; drv_signed = 0;
    drv_a = '0; drv_b = '0; drv_op = '0; use_exp = 0; drv_exp = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov0", {31'b0, if0.out_valid}, 0);
    chk("rst_res0", {29'b0, if0.out_y, if0.out_lt, if0.out_eq}, 0);
    chk("rst_ov1", {31'b0, if1.out_valid}, 0);
    chk("rst_res1", {29'b0, if1.out_y, if1.out_lt, if1.out_eq}, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_ready0", {31'b0, if0.in_ready}, 1);
    chk("rel_ready1", {31'b0, if1.in_ready}, 1);

    // Directed corners on the 4-stage instance, {y, lt, eq} as expected.
    lat_on = 1;
    beat(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'd0, 1, 3'b110, t);
    beat(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'd0, 1, 3'b000, t);
    beat(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'd4, 1, 3'b101, t);
    beat(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'd5, 1, 3'b001, t);
    beat(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'd1, 1, 3'b101, t);
    beat(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'd2, 1, 3'b001, t);
    beat(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'd6, 1, 3'b001, t);
    beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'd3, 1, 3'b010, t);
    beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3'd2, 1, 3'b100, t);
    beat(32'h1234_5678, 32'h1234_5679, 1'b0, 3'd1, 1, 3'b110, t);
    drain();

    // Back-to-back beats: accepted every cycle, each out after 4 cycles.
    for (int i = 0; i < 8; i++) begin
      rand_operands();
      beat(drv_a, drv_b, drv_signed, drv_op, 0, 3'b000, t);
      chk("b2b_ready", t, 1);
    end
    drain();
    lat_on = 0;

    // Stall under continuous input: exactly 4 beats fit, then full-pipe pass-through.
    drv_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      rand_operands();
      drv_valid = 1'b1;
      step();
    end
    chk("stall_accepts", n_acc - acc0, 4);
    chk("stall_in_ready", {31'b0, last_ir}, 0);
    drv_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_operands();
      drv_valid = 1'b1;
      step();
      chk("full_passthru_ready", {31'b0, last_ir}, 1);
    end
    drain();

    // Asynchronous reset with three beats in flight and one at the output.
    for (int i = 0; i < 3; i++) begin
      rand_operands();
      beat(drv_a, drv_b, drv_signed, drv_op, 0, 3'b000, t);
    end
    drv_ready = 1'b0;
    step();
    #2;
    chk("pre_rst_ov", {31'b0, if0.out_valid}, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_ov", {31'b0, if0.out_valid}, 0);
    chk("rst_async_res", {29'b0, if0.out_y, if0.out_lt, if0.out_eq}, 0);
    chk("rst_async_ready", {31'b0, if0.in_ready}, 1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    drv_ready = 1'b1;
    repeat (8) step();
    chk("post_rst_ready", {31'b0, last_ir}, 1);

    // Random traffic with random backpressure on the 4-stage instance.
    for (int i = 0; i < 3000; i++) begin
      rand_operands();
      drv_valid = ($urandom % 4) != 0;
      drv_ready = ($urandom % 4) != 0;
      step();
    end
    drain();

    // Single-stage instance.
    sel = 1;
    lat_on = 1;
    beat(32'h0000_0001, 32'h0000_FFFF, 1'b1, 3'd2, 1, 3'b100, t);
    beat(32'h0000_0001, 32'h0000_FFFF, 1'b0, 3'd2, 1, 3'b010, t);
    drain();
    lat_on = 0;
    for (int i = 0; i < 10000; i++) begin
      rand_operands();
      drv_valid = ($urandom % 4) != 0;
      drv_ready = ($urandom % 4) != 0;
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
